rtp_engine_up_initiator: RTL and testbench

Bus initiator for the up_* register interface: accepts one register command at a time (write or read) on a valid/ready stream, drives the matching up_wreq/up_rreq pulse toward a register-map responder, waits for the acknowledge, and returns a response with read data and a timeout error flag. It sits between an on-chip sequencer or DMA descriptor engine and any up_* regmap in the rtp_engine, so register programming (start/stop, line count) does not need a processor.

---
 rtl/rtp_engine_up_initiator_if.sv | 50 +++++
 rtl/rtp_engine_up_initiator.sv | 195 +++++++++++++++++++
 tb/tb_rtp_engine_up_initiator.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtp_engine_up_initiator_if.sv
// ----------------------------------------------------------------------------
// rtp_engine_up_initiator_if
// Bundles the command stream, the response stream and the up_* register bus
// around rtp_engine_up_initiator.
//
// Handshake semantics (cmd_* and rsp_*): a beat transfers at a rising edge
// where valid and ready are both high. Once valid is raised, the source holds
// valid and its payload stable until that edge. ready may change freely.
//
// Modports:
//   master : the initiator (drives cmd_ready, rsp_*, up_wreq/up_rreq + addr/data)
//   slave  : its environment (command source, response sink, regmap responder)
// ----------------------------------------------------------------------------
interface rtp_engine_up_initiator_if;
  // command stream
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [13:0] cmd_addr;
  logic [31:0] cmd_wdata;
  // response stream
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  // up_* register bus
  logic        up_wreq;
  logic [13:0] up_waddr;
  logic [31:0] up_wdata;
  logic        up_wack;
  logic        up_rreq;
  logic [13:0] up_raddr;
  logic [31:0] up_rdata;
  logic        up_rack;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           up_wack, up_rdata, up_rack,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_error,
           up_wreq, up_waddr, up_wdata, up_rreq, up_raddr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           up_wack, up_rdata, up_rack,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_error,
           up_wreq, up_waddr, up_wdata, up_rreq, up_raddr
  );
endinterface

// File: rtl/rtp_engine_up_initiator.sv
// ----------------------------------------------------------------------------
// rtp_engine_up_initiator
// Register-bus initiator: takes one write/read command at a time, issues a
// single-cycle up_wreq/up_rreq toward an up_* regmap, waits for the matching
// acknowledge and returns a response (read data, timeout error flag).
//
// Ports:
//   up_clk     clock
//   up_rstn    asynchronous active-low reset
//   bus        rtp_engine_up_initiator_if.master (cmd_*, rsp_*, up_* bus)
//   busy       high whenever the FSM is not IDLE
//   state_dbg  current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 RESP)
//
// Parameter:
//   TIMEOUT_CYCLES  WAIT cycles allowed before an error response (2..65535)
//
// Build option:
//   RTP_ENGINE_UP_INIT_TIMEOUT_EN  when defined, WAIT is bounded by
//   TIMEOUT_CYCLES and a missing ack yields rsp_error=1. When undefined,
//   WAIT lasts until the matching ack and rsp_error is constant 0.
//
// Every output is a flop; nothing on the interface is combinational from an
// input.
// ----------------------------------------------------------------------------
module rtp_engine_up_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                             up_clk,
  input  logic                             up_rstn,
  rtp_engine_up_initiator_if.master        bus,
  output logic                             busy,
  output logic [1:0]                       state_dbg
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 2..65535");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t      state_q, state_d;

  logic        wr_q;          // latched command direction
  logic        cmd_ready_q;
  logic        rsp_valid_q;
  logic        rsp_write_q;
  logic [31:0] rsp_rdata_q;
  logic        busy_q;
  logic        up_wreq_q;
  logic        up_rreq_q;
  logic [13:0] up_waddr_q;
  logic [31:0] up_wdata_q;
  logic [13:0] up_raddr_q;

  logic        accept;        // command handshake this edge
  logic        ack_hit;       // matching ack for the latched direction
  logic        done_ok;       // WAIT completes on ack

`ifdef RTP_ENGINE_UP_INIT_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt_q;
  logic        done_to;       // WAIT expires without ack
  logic        rsp_error_q;
`endif

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done_ok = 1'b0;
`ifdef RTP_ENGINE_UP_INIT_TIMEOUT_EN
    done_to = 1'b0;
`endif
    // Only the ack that matches the latched direction counts; the other is
    // deliberately ignored.
    ack_hit = wr_q ? bus.up_wack : bus.up_rack;
    case (state_q)
      ST_IDLE: begin
        // cmd_ready_q is what the source sees; it is low for the first
        // cycle after reset, so gate on it rather than on the state alone.
        if (bus.cmd_valid && cmd_ready_q) begin
          accept  = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // Single request cycle; acks seen here are not examined.
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (ack_hit) begin
          done_ok = 1'b1;
          state_d = ST_RESP;
        end
`ifdef RTP_ENGINE_UP_INIT_TIMEOUT_EN
        // Ack is tested first so an ack in the last permitted cycle wins.
        else if (tmo_cnt_q == TMO_LAST) begin
          done_to = 1'b1;
          state_d = ST_RESP;
        end
`endif
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------ registered outputs
  // Stream/status flags are computed from the next state so they line up
  // with state_q while still being flops.
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      wr_q        <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      busy_q      <= 1'b0;
      up_wreq_q   <= 1'b0;
      up_rreq_q   <= 1'b0;
      up_waddr_q  <= 14'd0;
      up_wdata_q  <= 32'd0;
      up_raddr_q  <= 14'd0;
    end else begin
      cmd_ready_q <= (state_d == ST_IDLE);
      rsp_valid_q <= (state_d == ST_RESP);
      busy_q      <= (state_d != ST_IDLE);
      // Request pulses are high exactly for the REQ cycle.
      up_wreq_q   <= accept &&  bus.cmd_write;
      up_rreq_q   <= accept && !bus.cmd_write;
      if (accept) begin
        wr_q <= bus.cmd_write;
        if (bus.cmd_write) begin
          up_waddr_q <= bus.cmd_addr;
          up_wdata_q <= bus.cmd_wdata;
        end else begin
          up_raddr_q <= bus.cmd_addr;
        end
      end
      if (done_ok) begin
        rsp_write_q <= wr_q;
        rsp_rdata_q <= wr_q ? 32'd0 : bus.up_rdata;
      end
`ifdef RTP_ENGINE_UP_INIT_TIMEOUT_EN
      else if (done_to) begin
        rsp_write_q <= wr_q;
        rsp_rdata_q <= 32'd0;
      end
`endif
    end
  end

`ifdef RTP_ENGINE_UP_INIT_TIMEOUT_EN
  // Counter restarts while in REQ so it reads 0 on the first WAIT cycle.
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      tmo_cnt_q   <= 16'd0;
      rsp_error_q <= 1'b0;
    end else begin
      if (state_q == ST_REQ)       tmo_cnt_q <= 16'd0;
      else if (state_q == ST_WAIT) tmo_cnt_q <= tmo_cnt_q + 16'd1;
      if (done_ok)      rsp_error_q <= 1'b0;
      else if (done_to) rsp_error_q <= 1'b1;
    end
  end
  assign bus.rsp_error = rsp_error_q;
`else
  assign bus.rsp_error = 1'b0;
`endif

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.up_wreq   = up_wreq_q;
  assign bus.up_waddr  = up_waddr_q;
  assign bus.up_wdata  = up_wdata_q;
  assign bus.up_rreq   = up_rreq_q;
  assign bus.up_raddr  = up_raddr_q;
  assign busy          = busy_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_rtp_engine_up_initiator.sv
// ----------------------------------------------------------------------------
// tb_rtp_engine_up_initiator
// Directed bench for rtp_engine_up_initiator. Inputs are driven 1 time unit
// after each rising edge and outputs are sampled at that same point, away
// from the active edge. Expected values are hand-derived from the edge
// numbering E0 = accept edge.
// ----------------------------------------------------------------------------
module tb_rtp_engine_up_initiator;

  localparam int unsigned TMO = 16;

  logic       up_clk = 1'b0;
  logic       up_rstn;
  logic       busy;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  rtp_engine_up_initiator_if bus ();

  rtp_engine_up_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
    .up_clk    (up_clk),
    .up_rstn   (up_rstn),
    .bus       (bus),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ------------------------------------------------------ clock / reset
  always #5 up_clk = ~up_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------ helpers
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge up_clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 14'd0;
    bus.cmd_wdata = 32'd0;
    bus.rsp_ready = 1'b0;
    bus.up_wack   = 1'b0;
    bus.up_rack   = 1'b0;
    bus.up_rdata  = 32'd0;
  endtask

  // Present a command until accepted; returns at E0+1.
  task automatic send_cmd(input logic w, input logic [13:0] a, input logic [31:0] d);
    logic acc;
    logic done;
    done = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    for (int i = 0; i < 20 && !done; i++) begin
      acc = bus.cmd_ready;
      tick();
      if (acc) done = 1'b1;
    end
    bus.cmd_valid = 1'b0;
    check("cmd_accept", {31'd0, done}, 32'd1);
    check("cmd_ready_drop", bus.cmd_ready, 1'b0);
    check("req_w", bus.up_wreq, w);
    check("req_r", bus.up_rreq, !w);
    if (w) begin
      check("up_waddr", bus.up_waddr, a);
      check("up_wdata", bus.up_wdata, d);
    end else begin
      check("up_raddr", bus.up_raddr, a);
    end
  endtask

  // Responder: matching ack sampled at edge E(n+1); checks the response there.
  task automatic ack_and_check(input logic w, input int n, input logic [31:0] rd,
                               input logic [31:0] exp_rd);
    for (int k = 1; k <= n; k++) begin
      tick();
      if (k == 1) check("req_one_cycle", {bus.up_wreq, bus.up_rreq}, 2'b00);
      if (k == n) begin
        if (w) bus.up_wack = 1'b1;
        else   bus.up_rack = 1'b1;
        bus.up_rdata = rd;
      end
    end
    check("no_early_rsp", bus.rsp_valid, 1'b0);
    tick();
    bus.up_wack = 1'b0;
    bus.up_rack = 1'b0;
    check("rsp_valid", bus.rsp_valid, 1'b1);
    check("rsp_write", bus.rsp_write, w);
    check("rsp_error", bus.rsp_error, 1'b0);
    check("rsp_rdata", bus.rsp_rdata, exp_rd);
  endtask

  task automatic consume();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("rsp_done", bus.rsp_valid, 1'b0);
    check("ready_again", bus.cmd_ready, 1'b1);
    check("busy_clear", busy, 1'b0);
  endtask

  // Assert reset mid-cycle: outputs must drop without any clock edge.
  task automatic reset_pulse(input string tag);
    #2 up_rstn = 1'b0;
    #1;
    check({tag, "_wreq"}, bus.up_wreq, 1'b0);
    check({tag, "_rreq"}, bus.up_rreq, 1'b0);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_state"}, state_dbg, 2'd0);
    #1 up_rstn = 1'b1;
    tick();
    check({tag, "_ready_rise"}, bus.cmd_ready, 1'b1);
    bus.up_wack  = 1'b1;
    bus.up_rack  = 1'b1;
    tick();
    bus.up_wack  = 1'b0;
    bus.up_rack  = 1'b0;
    tick();
    check({tag, "_no_stale_rsp"}, bus.rsp_valid, 1'b0);
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  // ------------------------------------------------------ stimulus
  initial begin
    idle_inputs();
    up_rstn = 1'b0;
    #12;
    check("rst_cmd_ready", bus.cmd_ready, 1'b0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_write", bus.rsp_write, 1'b0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_rsp_error", bus.rsp_error, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_wreq", bus.up_wreq, 1'b0);
    check("rst_rreq", bus.up_rreq, 1'b0);
    check("rst_waddr", bus.up_waddr, 14'd0);
    check("rst_raddr", bus.up_raddr, 14'd0);
    check("rst_wdata", bus.up_wdata, 32'd0);
    check("rst_state", state_dbg, 2'd0);
    @(negedge up_clk);
    up_rstn = 1'b1;
    tick();
    check("ready_after_rst", bus.cmd_ready, 1'b1);

    // Write 0x4 <- 0x123, ack one cycle after request; rdata must read 0.
    send_cmd(1'b1, 14'h4, 32'h0000_0123);
    check("busy_in_req", busy, 1'b1);
    ack_and_check(1'b1, 1, 32'hCAFE_F00D, 32'd0);
    consume();

    // Read 0x0 returns 1; write-side registers keep their last value.
    send_cmd(1'b0, 14'h0, 32'hFFFF_FFFF);
    check("waddr_hold", bus.up_waddr, 14'h4);
    check("wdata_hold", bus.up_wdata, 32'h123);
    ack_and_check(1'b0, 1, 32'h0000_0001, 32'h0000_0001);
    consume();

    // Write answered first by the wrong ack, then by up_wack.
    send_cmd(1'b1, 14'h10, 32'hA5A5_0001);
    tick();                               // E1
    bus.up_rack  = 1'b1;
    bus.up_rdata = 32'hDEAD_BEEF;
    tick();                               // E2
    check("rack_ignored", bus.rsp_valid, 1'b0);
    bus.up_rack = 1'b0;
    repeat (3) tick();                    // E5
    check("wait_for_wack", bus.rsp_valid, 1'b0);
    bus.up_wack = 1'b1;
    tick();                               // E6
    bus.up_wack = 1'b0;
    check("wack_rsp_valid", bus.rsp_valid, 1'b1);
    check("wack_rsp_write", bus.rsp_write, 1'b1);
    check("wack_rsp_error", bus.rsp_error, 1'b0);
    check("wack_rsp_rdata", bus.rsp_rdata, 32'd0);
    consume();

    // Ack sampled during REQ must not complete the read.
    send_cmd(1'b0, 14'h3, 32'd0);
    bus.up_rack  = 1'b1;
    bus.up_rdata = 32'h0000_0077;
    tick();                               // E1 (REQ)
    bus.up_rack  = 1'b0;
    tick();                               // E2
    check("req_ack_ignored", bus.rsp_valid, 1'b0);
    bus.up_rack  = 1'b1;
    bus.up_rdata = 32'h0000_0099;
    tick();                               // E3
    bus.up_rack  = 1'b0;
    check("after_req_ack_valid", bus.rsp_valid, 1'b1);
    check("after_req_ack_rdata", bus.rsp_rdata, 32'h0000_0099);
    consume();

`ifdef RTP_ENGINE_UP_INIT_TIMEOUT_EN
    // Read 0x2 with no ack: response at E17 with error.
    send_cmd(1'b0, 14'h2, 32'd0);
    repeat (TMO) tick();                  // E16
    check("tmo_not_early", bus.rsp_valid, 1'b0);
    tick();                               // E17
    check("tmo_rsp_valid", bus.rsp_valid, 1'b1);
    check("tmo_rsp_error", bus.rsp_error, 1'b1);
    check("tmo_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("tmo_rsp_write", bus.rsp_write, 1'b0);
    consume();                            // E18
    repeat (2) tick();                    // E20
    bus.up_rack  = 1'b1;
    bus.up_rdata = 32'h0000_1234;
    tick();                               // E21: late ack
    bus.up_rack  = 1'b0;
    check("late_ack_ignored", bus.rsp_valid, 1'b0);
    check("late_ack_idle", busy, 1'b0);
    send_cmd(1'b0, 14'h5, 32'd0);
    ack_and_check(1'b0, 1, 32'h0000_0055, 32'h0000_0055);
    consume();
    // Ack in the last permitted WAIT cycle beats the timeout.
    send_cmd(1'b0, 14'h6, 32'd0);
    ack_and_check(1'b0, TMO, 32'h0000_ABCD, 32'h0000_ABCD);
    consume();
`else
    // Without the timeout path WAIT holds until the matching ack.
    send_cmd(1'b0, 14'h2, 32'd0);
    repeat (30) tick();
    check("wait_persists_valid", bus.rsp_valid, 1'b0);
    check("wait_persists_busy", busy, 1'b1);
    bus.up_wack = 1'b1;
    tick();
    bus.up_wack = 1'b0;
    check("wait_wack_ignored", bus.rsp_valid, 1'b0);
    bus.up_rack  = 1'b1;
    bus.up_rdata = 32'h0000_0042;
    tick();
    bus.up_rack  = 1'b0;
    check("wait_rsp_valid", bus.rsp_valid, 1'b1);
    check("wait_rsp_error", bus.rsp_error, 1'b0);
    check("wait_rsp_rdata", bus.rsp_rdata, 32'h0000_0042);
    consume();
`endif

    // Response back-pressure with a second command waiting.
    send_cmd(1'b0, 14'h7, 32'd0);
    ack_and_check(1'b0, 1, 32'h0000_600D, 32'h0000_600D);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 14'h8;
    bus.cmd_wdata = 32'h0000_0088;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_rsp_valid", bus.rsp_valid, 1'b1);
      check("bp_cmd_ready", bus.cmd_ready, 1'b0);
      check("bp_rsp_rdata", bus.rsp_rdata, 32'h0000_600D);
      check("bp_rsp_write", bus.rsp_write, 1'b0);
    end
    bus.rsp_ready = 1'b1;
    tick();                               // handshake edge H
    bus.rsp_ready = 1'b0;
    check("bp_rsp_drop", bus.rsp_valid, 1'b0);
    check("bp_ready_rise", bus.cmd_ready, 1'b1);
    check("bp_no_req_yet", bus.up_wreq, 1'b0);
    tick();                               // H+1 accepts
    bus.cmd_valid = 1'b0;
    check("bp_second_accept", bus.up_wreq, 1'b1);
    check("bp_second_addr", bus.up_waddr, 14'h8);
    check("bp_second_data", bus.up_wdata, 32'h0000_0088);
    ack_and_check(1'b1, 1, 32'd0, 32'd0);
    consume();

    // Reset during REQ, WAIT and RESP.
    send_cmd(1'b0, 14'h9, 32'd0);
    reset_pulse("rst_req");
    send_cmd(1'b1, 14'hB, 32'h2);
    tick();                               // E1: WAIT
    reset_pulse("rst_wait");
    send_cmd(1'b1, 14'hA, 32'h1);
    ack_and_check(1'b1, 1, 32'd0, 32'd0);
    reset_pulse("rst_resp");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
